uart_rx_stdin: RTL

//  UART receiver (8N1, LSB first) on the board rx pin, feeding received bytes to the CPU stdin path.

---
 rtl/uart_rx_stdin_if.sv | 18 +
 rtl/uart_rx_stdin.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_stdin_if.sv
// rtl/uart_rx_stdin_if.sv - stdin byte handshake between UART receiver and consumer
interface uart_rx_stdin_if;
  logic [7:0] stdin_data;
  logic       stdin_valid;
  logic       stdin_ready;

  modport master (
    output stdin_data,
    output stdin_valid,
    input  stdin_ready
  );

  modport slave (
    input  stdin_data,
    input  stdin_valid,
    output stdin_ready
  );
endinterface

// File: rtl/uart_rx_stdin.sv
// rtl/uart_rx_stdin.sv - 8N1 UART receiver with small FIFO feeding the stdin handshake
module uart_rx_stdin #(
  parameter int BAUD    = 104,
  parameter int FIFO_AW = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  uart_rx_stdin_if.master stdin,
  output logic            o_overrun,
  output logic            o_frame_err
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [15:0]      HALF_M1 = 16'(BAUD / 2 - 1);
  localparam logic [15:0]      FULL_M1 = 16'(BAUD - 1);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  state_t             r_state;
  logic [15:0]        r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_overrun;
  logic               r_frame_err;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  logic w_rx_s;
  logic w_baud_half;
  logic w_baud_full;
  logic w_stop_sample;
  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_push;

  assign w_rx_s        = r_sync2;
  assign w_baud_half   = (r_baud_cnt == HALF_M1);
  assign w_baud_full   = (r_baud_cnt == FULL_M1);
  assign w_stop_sample = (r_state == S_STOP) && w_baud_full;
  assign w_push_req    = w_stop_sample && w_rx_s;
  assign w_pop         = (r_count != '0) && stdin.stdin_ready;
  assign w_full        = (r_count == DEPTH_C);
  // A full FIFO still takes the byte when the consumer frees a slot the same cycle.
  assign w_push        = w_push_req && (!w_full || w_pop);

  assign stdin.stdin_valid = (r_count != '0);
  assign stdin.stdin_data  = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign o_overrun         = r_overrun;
  assign o_frame_err       = r_frame_err;

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: start-bit qualification at half a bit, data/stop sampled at bit centres.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (w_baud_half) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_full) begin
            r_baud_cnt <= '0;
            r_shift    <= {w_rx_s, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_full) begin
            r_baud_cnt <= '0;
            if (w_rx_s) begin
              r_overrun <= !w_push;
              r_state   <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        S_BREAK: begin
          r_baud_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Circular byte FIFO; head entry is shown directly so data is first-word-fall-through.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
